// File: rtl/dig_top_pkg.sv
// Shared types and constants for the audio DAC digital front end.
// Holds register map, I2C state encoding, config payload and the volume/code helpers.
package dig_top_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CODE_W = 24;
  localparam int unsigned C_W    = 6;
  localparam int unsigned B_W    = 18;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned VOL_W  = 8;
  localparam int unsigned PROD_W = CODE_W + VOL_W + 1;
  localparam int unsigned VOL_SHIFT = 7;

  localparam logic [6:0]        I2C_ADDR    = 7'b0010110;
  localparam logic [REG_W-1:0]  VOL_DEFAULT = 8'h80;
  localparam logic [REG_W-1:0]  REG_VOL_L   = 8'h00;
  localparam logic [REG_W-1:0]  REG_VOL_R   = 8'h01;
  localparam logic [REG_W-1:0]  REG_CTRL    = 8'h02;
  localparam logic [CODE_W-1:0] MID_SCALE   = 24'h800000;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 33'sd8388607;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -33'sd8388608;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK
  } i2c_state_t;

  typedef struct packed {
    logic [VOL_W-1:0] vol_l;
    logic [VOL_W-1:0] vol_r;
    logic             swap;
    logic             mute;
  } dac_cfg_t;

  localparam dac_cfg_t CFG_RESET = '{vol_l: VOL_DEFAULT, vol_r: VOL_DEFAULT,
                                     swap: 1'b0, mute: 1'b0};

  // Signed sample times unsigned Q1.7 volume, saturated, as offset-binary code.
  function automatic logic [CODE_W-1:0] scale_code(input logic [CODE_W-1:0] s,
                                                   input logic [VOL_W-1:0]  vol,
                                                   input logic              mute);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] y;
    logic [CODE_W-1:0]        ys;
    p = PROD_W'($signed(s)) * PROD_W'($signed({1'b0, vol}));
    y = p >>> VOL_SHIFT;
    if (mute)             ys = '0;
    else if (y > SAT_MAX) ys = 24'h7FFFFF;
    else if (y < SAT_MIN) ys = 24'h800000;
    else                  ys = CODE_W'(y);
    return {~ys[CODE_W-1], ys[CODE_W-2:0]};
  endfunction

  function automatic logic [REG_W-1:0] reg_read(input dac_cfg_t cfg,
                                                input logic [REG_W-1:0] addr);
    case (addr)
      REG_VOL_L: return cfg.vol_l;
      REG_VOL_R: return cfg.vol_r;
      REG_CTRL:  return {6'b0, cfg.swap, cfg.mute};
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_slave_regs.sv
// I2C slave (oversampled on m_clk) plus the volume/control register file.
// Define I2C_READ_EN to add register read-back; otherwise reads are NACKed.
module i2c_slave_regs
  import dig_top_pkg::*;
(
  input  logic     m_clk,
  input  logic     rst_n,
  input  logic     i2c_scl,
  input  logic     i2c_sdain,
  output logic     i2c_sdaout,
  output logic     i2c_sdaout_en,
  output dac_cfg_t cfg
);

  logic [1:0]       scl_sync;
  logic [1:0]       sda_sync;
  logic             scl_d;
  logic             sda_d;
  logic             scl_s;
  logic             sda_s;
  logic             scl_rise_c;
  logic             scl_fall_c;
  logic             start_c;
  logic             stop_c;
  i2c_state_t       state;
  logic [2:0]       bit_cnt;
  logic [REG_W-2:0] shift;
  logic [REG_W-1:0] ptr;
  logic             ack_ph;
  logic [REG_W-1:0] byte_c;
`ifdef I2C_READ_EN
  logic             rd;
  logic [REG_W-2:0] tx;
  logic [REG_W-1:0] rd_byte_c;

  assign rd_byte_c = reg_read(cfg, ptr);
`endif

  assign i2c_sdaout = 1'b0;
  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_c     = {shift, sda_s};

  // Idle bus is high, so synchronisers reset to 1 to avoid a false START/STOP.
  always_ff @(posedge m_clk or posedge rst_n) begin
    if (rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sdain};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge m_clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      ptr           <= '0;
      ack_ph        <= 1'b0;
      i2c_sdaout_en <= 1'b0;
      cfg           <= CFG_RESET;
`ifdef I2C_READ_EN
      rd            <= 1'b0;
      tx            <= '0;
`endif
    end else if (start_c) begin
      state         <= ST_ADDR;
      bit_cnt       <= '0;
      ack_ph        <= 1'b0;
      i2c_sdaout_en <= 1'b0;
`ifdef I2C_READ_EN
      rd            <= 1'b0;
`endif
    end else if (stop_c) begin
      state         <= ST_IDLE;
      ack_ph        <= 1'b0;
      i2c_sdaout_en <= 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_REG: begin
          if (scl_rise_c) begin
            shift   <= byte_c[REG_W-2:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_REG) begin
                ptr   <= byte_c;
                state <= ST_REG_ACK;
              end else if (byte_c[7:1] == I2C_ADDR && !byte_c[0]) begin
                state <= ST_ADDR_ACK;
`ifdef I2C_READ_EN
              end else if (byte_c[7:1] == I2C_ADDR) begin
                state <= ST_ADDR_ACK;
                rd    <= 1'b1;
`endif
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_DATA: begin
`ifdef I2C_READ_EN
          if (rd) begin
            if (scl_rise_c) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_DATA_ACK;
                ptr   <= ptr + 8'd1;
              end
            end else if (scl_fall_c && bit_cnt != 3'd0) begin
              i2c_sdaout_en <= ~tx[REG_W-2];
              tx            <= {tx[REG_W-3:0], 1'b0};
            end
          end else
`endif
          if (scl_rise_c) begin
            shift   <= byte_c[REG_W-2:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (ptr)
                REG_VOL_L: cfg.vol_l <= byte_c;
                REG_VOL_R: cfg.vol_r <= byte_c;
                REG_CTRL: begin
                  cfg.mute <= byte_c[0];
                  cfg.swap <= byte_c[1];
                end
                default: ;
              endcase
              ptr   <= ptr + 8'd1;
              state <= ST_DATA_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
`ifdef I2C_READ_EN
          // Master acknowledge after a read byte: NACK ends the read.
          if (rd && state == ST_DATA_ACK) begin
            if (scl_rise_c && sda_s) begin
              state <= ST_IDLE;
            end else if (scl_fall_c) begin
              ack_ph <= ~ack_ph;
              if (!ack_ph) begin
                i2c_sdaout_en <= 1'b0;
              end else begin
                state         <= ST_DATA;
                bit_cnt       <= '0;
                tx            <= rd_byte_c[REG_W-2:0];
                i2c_sdaout_en <= ~rd_byte_c[REG_W-1];
              end
            end
          end else
`endif
          // Pull SDA low from the fall after bit 8 until the following fall.
          if (scl_fall_c) begin
            ack_ph        <= ~ack_ph;
            i2c_sdaout_en <= ~ack_ph;
            if (ack_ph) begin
              bit_cnt <= '0;
              state   <= (state == ST_ADDR_ACK) ? ST_REG : ST_DATA;
`ifdef I2C_READ_EN
              if (rd) begin
                state         <= ST_DATA;
                tx            <= rd_byte_c[REG_W-2:0];
                i2c_sdaout_en <= ~rd_byte_c[REG_W-1];
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dig_top.sv
// Audio DAC digital front end: I2S receiver, per-channel volume/mute/swap, segmented codes.
// Register read-back over I2C is built only when I2C_READ_EN is defined.
module dig_top
  import dig_top_pkg::*;
(
  input  logic           m_clk,
  input  logic           rst_n,
  input  logic           i2s_sck,
  input  logic           i2s_lrclk,
  input  logic           i2s_sdin,
  input  logic           i2c_scl,
  input  logic           i2c_sdain,
  output logic           i2c_sdaout,
  output logic           i2c_sdaout_en,
  output logic [C_W-1:0] SVCout,
  output logic [B_W-1:0] SVBout,
  output logic [C_W-1:0] STCout,
  output logic [B_W-1:0] STBout
);

  dac_cfg_t          cfg;
  logic [1:0]        sck_sync;
  logic [1:0]        lr_sync;
  logic [1:0]        sd_sync;
  logic              sck_d;
  logic              sck_rise_c;
  logic              lr_edge_c;
  logic              lr_prev;
  logic              lr_vld;
  logic              lat_l;
  logic              sample_stb;
  logic [WORD_W-1:0] shift;
  logic [CODE_W-1:0] word_l;
  logic [CODE_W-1:0] word_r_c;
  logic [CODE_W-1:0] sv_code;
  logic [CODE_W-1:0] st_code;

  i2c_slave_regs u_i2c (
    .m_clk         (m_clk),
    .rst_n         (rst_n),
    .i2c_scl       (i2c_scl),
    .i2c_sdain     (i2c_sdain),
    .i2c_sdaout    (i2c_sdaout),
    .i2c_sdaout_en (i2c_sdaout_en),
    .cfg           (cfg)
  );

  assign sck_rise_c = sck_sync[1] & ~sck_d;
  assign lr_edge_c  = lr_vld & (lr_sync[1] != lr_prev);
  // Right word is still sitting in the shift register on the strobe cycle.
  assign word_r_c   = shift[WORD_W-1 -: CODE_W];

  // I2S receive: the rise after an lrclk change carries the previous word's LSB.
  always_ff @(posedge m_clk or posedge rst_n) begin
    if (rst_n) begin
      sck_sync   <= '0;
      lr_sync    <= '0;
      sd_sync    <= '0;
      sck_d      <= 1'b0;
      lr_prev    <= 1'b0;
      lr_vld     <= 1'b0;
      lat_l      <= 1'b0;
      sample_stb <= 1'b0;
      shift      <= '0;
      word_l     <= '0;
    end else begin
      sck_sync   <= {sck_sync[0], i2s_sck};
      lr_sync    <= {lr_sync[0], i2s_lrclk};
      sd_sync    <= {sd_sync[0], i2s_sdin};
      sck_d      <= sck_sync[1];
      lat_l      <= 1'b0;
      sample_stb <= 1'b0;
      if (sck_rise_c) begin
        shift   <= {shift[WORD_W-2:0], sd_sync[1]};
        lr_prev <= lr_sync[1];
        lr_vld  <= 1'b1;
        if (lr_edge_c) begin
          if (lr_sync[1]) lat_l      <= 1'b1;
          else            sample_stb <= 1'b1;
        end
      end
      if (lat_l) word_l <= shift[WORD_W-1 -: CODE_W];
    end
  end

  // Swap routes inputs; volumes stay with their output channel.
  always_ff @(posedge m_clk or posedge rst_n) begin
    if (rst_n) begin
      sv_code <= MID_SCALE;
      st_code <= MID_SCALE;
    end else if (sample_stb) begin
      sv_code <= scale_code(cfg.swap ? word_r_c : word_l, cfg.vol_l, cfg.mute);
      st_code <= scale_code(cfg.swap ? word_l : word_r_c, cfg.vol_r, cfg.mute);
    end
  end

  assign {SVCout, SVBout} = sv_code;
  assign {STCout, STBout} = st_code;

endmodule

// File: tb/tb_dig_top.sv
// Directed self-checking bench for dig_top: I2S frames, I2C register writes, reset cases.
module tb_dig_top;

  localparam int Q = 10;

  logic        m_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sck   = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdin  = 1'b0;
  logic        scl   = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sdaout;
  logic        sdaout_en;
  logic [5:0]  svc, stc;
  logic [17:0] svb, stb;
  logic [23:0] prev_l, prev_r;
  int          n_chk = 0;
  int          n_fail = 0;
  int          en_cnt = 0;
  int          acks;
  int          en0;

  assign sda_bus = sda_m & ~sdaout_en;

  dig_top dut (
    .m_clk         (m_clk),
    .rst_n         (rst_n),
    .i2s_sck       (sck),
    .i2s_lrclk     (lrclk),
    .i2s_sdin      (sdin),
    .i2c_scl       (scl),
    .i2c_sdain     (sda_bus),
    .i2c_sdaout    (sdaout),
    .i2c_sdaout_en (sdaout_en),
    .SVCout        (svc),
    .SVBout        (svb),
    .STCout        (stc),
    .STBout        (stb)
  );

  always #10 m_clk = ~m_clk;

  always @(posedge m_clk) if (sdaout_en) en_cnt <= en_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge m_clk);
  endtask

  task automatic sck_bit(input logic lr, input logic d);
    sck = 1'b0; lrclk = lr; sdin = d;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(4);
  endtask

  // One I2S frame; the final rise carries the right LSB and is latency-checked.
  task automatic send_frame(input string tag, input logic [31:0] l, input logic [31:0] r,
                            input logic [23:0] exp_l, input logic [23:0] exp_r);
    logic [63:0] st;
    st = {l, r};
    sck_bit(1'b0, 1'b0);
    for (int j = 1; j < 64; j++) sck_bit(j >= 32, st[64-j]);
    sck = 1'b0; lrclk = 1'b0; sdin = st[0];
    wait_clk(4);
    sck = 1'b1;
    wait_clk(3);
    check_eq({tag, " hold L"}, 32'({svc, svb}), 32'(prev_l));
    check_eq({tag, " hold R"}, 32'({stc, stb}), 32'(prev_r));
    wait_clk(1);
    check_eq({tag, " L"}, 32'({svc, svb}), 32'(exp_l));
    check_eq({tag, " R"}, 32'({stc, stb}), 32'(exp_r));
    prev_l = exp_l;
    prev_r = exp_r;
    wait_clk(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl = 1'b1;   wait_clk(2 * Q);
      scl = 1'b0;   wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    ack = sdaout_en;
    wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int n, output int nack);
    logic [7:0] bs [4];
    logic       a;
    bs = '{b0, b1, b2, b3};
    nack = 0;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      i2c_byte(bs[i], a);
      nack += int'(a);
    end
    i2c_stop();
  endtask

  initial begin
    wait_clk(5);
    check_eq("rst SV code", 32'({svc, svb}), 32'h800000);
    check_eq("rst ST code", 32'({stc, stb}), 32'h800000);
    check_eq("rst sdaout_en", 32'(sdaout_en), 32'h0);
    check_eq("rst sdaout", 32'(sdaout), 32'h0);
    rst_n = 1'b0;
    wait_clk(5);
    prev_l = 24'h800000;
    prev_r = 24'h800000;

    send_frame("gain", 32'h7FFFFF00, 32'h80000000, 24'hFFFFFF, 24'h000000);

    i2c_xfer(8'h2C, 8'h00, 8'h40, 8'h00, 3, acks);
    check_eq("vol_l acks", 32'(acks), 32'd3);
    send_frame("vol_l", 32'h40000000, 32'h00000000, 24'hA00000, 24'h800000);

    i2c_xfer(8'h2C, 8'h01, 8'hFF, 8'h00, 3, acks);
    check_eq("vol_r acks", 32'(acks), 32'd3);
    send_frame("sat pos", 32'h00000000, 32'h60000000, 24'h800000, 24'hFFFFFF);
    send_frame("sat neg", 32'hC0000000, 32'hA0000000, 24'h600000, 24'h000000);

    en0 = en_cnt;
    i2c_xfer(8'h2D, 8'h00, 8'h10, 8'h00, 3, acks);
    check_eq("read nack acks", 32'(acks), 32'd0);
    check_eq("read nack en", 32'(en_cnt), 32'(en0));
    i2c_xfer(8'h2E, 8'h01, 8'h10, 8'h00, 3, acks);
    check_eq("bad addr acks", 32'(acks), 32'd0);
    check_eq("bad addr en", 32'(en_cnt), 32'(en0));
    i2c_xfer(8'h2C, 8'h03, 8'h55, 8'h00, 3, acks);
    check_eq("reg3 acks", 32'(acks), 32'd3);
    send_frame("regs kept", 32'h40000000, 32'h60000000, 24'hA00000, 24'hFFFFFF);

    i2c_xfer(8'h2C, 8'h02, 8'h01, 8'h00, 3, acks);
    check_eq("mute acks", 32'(acks), 32'd3);
    send_frame("mute", 32'h7FFFFF00, 32'h80000000, 24'h800000, 24'h800000);

    // Auto-increment: vol_r then control (swap on, mute off).
    i2c_xfer(8'h2C, 8'h01, 8'h80, 8'h02, 4, acks);
    check_eq("swap acks", 32'(acks), 32'd4);
    send_frame("swap", 32'h40000000, 32'h00000000, 24'h800000, 24'hC00000);

    // Reset in the middle of an I2S word and an I2C address byte.
    for (int j = 0; j < 20; j++) sck_bit(j >= 10, 1'b1);
    i2c_start();
    sda_m = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q); scl = 1'b0; wait_clk(Q);
    rst_n = 1'b1;
    wait_clk(3);
    check_eq("midrst SV code", 32'({svc, svb}), 32'h800000);
    check_eq("midrst ST code", 32'({stc, stb}), 32'h800000);
    check_eq("midrst sdaout_en", 32'(sdaout_en), 32'h0);
    sck = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    sda_m = 1'b1; wait_clk(2);
    scl = 1'b1;   wait_clk(2);
    rst_n = 1'b0;
    wait_clk(5);
    prev_l = 24'h800000;
    prev_r = 24'h800000;
    send_frame("post rst", 32'h20000000, 32'hE0000000, 24'hA00000, 24'h600000);
    i2c_xfer(8'h2C, 8'h00, 8'h40, 8'h00, 3, acks);
    check_eq("post rst acks", 32'(acks), 32'd3);
    send_frame("post rst vol", 32'h40000000, 32'h40000000, 24'hA00000, 24'hC00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dig_top.md
# dig_top

Digital front end of the audio DAC. It receives 32-bit stereo I2S audio, applies per-channel volume, mute and channel swap configured over an I2C write-only slave, and drives two 24-bit offset-binary DAC codes. Each code is split into a 6-bit coarse segment (C) and an 18-bit fine segment (B) for the analog array. All logic runs on the master clock; I2S and I2C pins are asynchronous inputs that are oversampled.

## Interface
- I2C_ADDR, 7'b0010110: 7-bit slave address.
- VOL_DEFAULT, 8'h80: reset value of both volume registers (unity gain).
- m_clk  in  1  master clock, 49.152 MHz.
- rst_n  in  1  reset. Asynchronous, active-high (asserted when 1).
- i2s_sck  in  1  I2S bit clock, 64×fs.
- i2s_lrclk  in  1  word select. 0 = left, 1 = right.
- i2s_sdin  in  1  I2S serial data, MSB first, one-bit delay.
- i2c_scl  in  1  I2C clock, up to 400 kHz.
- i2c_sdain  in  1  I2C data in.
- i2c_sdaout  out  1  I2C data out. Constant 0 without read support.
- i2c_sdaout_en  out  1  open-drain enable. 1 pulls SDA low.
- SVCout / SVBout  out  6 / 18  left code, coarse / fine.
- STCout / STBout  out  6 / 18  right code, coarse / fine.

## Operation
- **Synchronisers.** Every async input passes through a 2-flop synchroniser. Edges are detected on the synchronised value.
- **I2S receiver.**
  - Data is shifted into a 32-bit register on each sck rising edge.
  - A lrclk change marks that the bit one sck later is the new word's MSB.
  - Left LSB arrives on the first rise after lrclk goes 0→1. That rise latches the left word.
  - Right LSB arrives on the first rise after lrclk goes 1→0. That rise latches the right word and pulses sample_stb.
  - A word is the 32 bits ending at its LSB; there is no bit counter.
- **Datapath.** Runs on sample_stb and uses the register values latched at that strobe.
  - s = word[31:24+…], i.e. word[31:8], signed 24-bit.
  - p = s × vol, where vol is unsigned 8-bit.
  - y = p >>> 7 (arithmetic shift), saturated to [−2^23, 2^23−1].
  - Mute forces y = 0.
  - Swap exchanges the left and right inputs before volume. The volume registers stay attached to their output channel.
  - Output code = {~y[23], y[22:0]}. C = code[23:18], B = code[17:0].
- **I2C slave.**
  - States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK.
  - START (SDA falls while SCL=1) from any state goes to ADDR. A repeated START is legal.
  - STOP (SDA rises while SCL=1) from any state goes to IDLE.
  - Bits are sampled on scl rise.
  - Address match with R/W=0 → ACK. First byte = register pointer. Following bytes are written at the pointer, then the pointer increments (8-bit, wraps).
  - Mismatch, or R/W=1 → no ACK, return to IDLE until the next START.
  - ACK: sdaout_en=1 from the scl fall after bit 8 until the next scl fall.
- **Registers.** Writes to addresses ≥ 0x03 are ACKed and ignored.
  - 0x00: left volume.
  - 0x01: right volume.
  - 0x02: bit0 mute, bit1 swap, rest reserved (read as 0).

## Timing
- **Reset values.**
  - All C outputs 6'h20, all B outputs 0 (mid-scale).
  - sdaout_en=0, sdaout=0.
  - Volume registers = VOL_DEFAULT, control = 0.
  - I2C state IDLE, pointer = 0, shift registers 0.
- **Latency.** Outputs update exactly 4 m_clk cycles after the synchronised sck rising edge that carries the right LSB: 2 sync stages, 1 edge detect, 1 output register. Both channels update on the same cycle.
- **Register writes.** A write commits on the scl rise of data bit 0. It takes effect at the next sample_stb.
- **Reset mid-frame or mid-transfer.** The partial word or byte is discarded. After release, operation resumes cleanly at the next lrclk edge or the next START.

## Configuration
- **I2C_READ_EN defined.**
  - R/W=1 with an address match is ACKed.
  - The slave shifts the register at the pointer onto sdaout, MSB first, changing on scl fall. sdaout_en = ~bit.
  - Pointer increments per byte. Master NACK or STOP ends the read.
- **I2C_READ_EN undefined.** R/W=1 is NACKed and sdaout is tied to 0.

## Structure
- **Shared package dig_top_pkg:**
  - register addresses and widths;
  - I2C state enum;
  - mid-scale constant 24'h800000.
- **Sub-module:** i2c_slave_regs contains the synchronisers, I2C FSM and register file. The I2S receiver and datapath remain in dig_top.

## Test plan
1. **Reset.** Assert reset → SVCout=STCout=6'h20, SVBout=STBout=0, sdaout_en=0.
2. **Default gain.** Send frame left=32'h7FFFFF00, right=32'h80000000 → SVC=6'h3F, SVB=18'h3FFFF, STC=6'h00, STB=0, 4 cycles after the right LSB.
3. **Volume write.** I2C write 0x2C, 0x00, 0x40 → ACK on all 3 bytes. Then left=32'h40000000 → SVC=6'h28, SVB=0.
4. **Saturation.** Write reg 0x01=0xFF, then right=32'h60000000 → STC=6'h3F, STB=18'h3FFFF.
5. **Wrong address.** Address byte 0x2D (addr 0x16, R/W=1) or 0x2E → sdaout_en stays 0 for the whole transfer, registers unchanged.
6. **Mute and swap.** Write 0x02=0x01 → all outputs mid-scale. Then write 0x02=0x02 with left=0x40000000, right=0 → left outputs mid-scale, right outputs C=6'h30.
